// File: rtl/tb_status_periph.sv
// Purpose: simulation status peripheral on the core data bus; stdout FIFO, cycle counter, terminal flags.
// Latency: bus response (rvalid/rdata) 1 cycle after grant; terminal flag 2 cycles after the status write (empty FIFO).
// Backpressure: a STDOUT write to a full FIFO is not granted; the printer side drains over stdout_valid/ready.
//
// Ports: clk_i/rst_i (sync, active-high); data_* = core data bus (req/gnt, addr/we/be/wdata, rvalid/rdata);
//        stdout_* = character stream to the printer; tests_passed_o/tests_failed_o/exit_valid_o/exit_value_o
//        = sticky terminal status for the simulation top.

// Generic FIFO: pointers wrap modulo DEPTH, count is one bit wider than the pointers.
// Head data reads as 0 while the FIFO is empty so the outputs are clean straight after reset.
module status_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign in_rdy  = (cnt_q != FULL_CNT);
  assign out_vld = (cnt_q != '0);
  assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
  assign do_push = in_vld && in_rdy;
  assign do_pop  = out_vld && out_rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers/count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= in_dat;
  end
endmodule

module tb_status_periph #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] STDOUT_ADDR = 32'h1000_0000,
  parameter logic [31:0] CTRL_BASE   = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC  = 32'd123456789,
  // Value loaded into the cycle counter at reset; nonzero only to bring the
  // 32-bit carry within reach of a short simulation.
  parameter logic [63:0] CYCLE_INIT  = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);
  localparam logic [29:0] W_STDOUT = STDOUT_ADDR[31:2];
  localparam logic [29:0] W_EXIT   = CTRL_BASE[31:2];
  localparam logic [29:0] W_STATUS = W_EXIT + 30'd1;
  localparam logic [29:0] W_CYC_LO = W_EXIT + 30'd2;
  localparam logic [29:0] W_CYC_HI = W_EXIT + 30'd3;

  typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_DONE} state_t;
  typedef enum logic [1:0] {KIND_EXIT, KIND_PASS, KIND_FAIL} kind_t;

  logic [29:0] word;
  logic        sel_stdout, sel_exit, sel_status, sel_cyc_lo, sel_cyc_hi;
  logic        bus_wr, bus_rd, fifo_push, fifo_in_rdy;
  logic [31:0] rd_val, rdata_q, hi_shadow_q, exit_val_q, exit_val_d;
  logic [63:0] cycle_q;
  logic        rvalid_q;
  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        unused_bits;

  assign unused_bits = ^{data_be_i[3:1], data_addr_i[1:0]};

  assign word       = data_addr_i[31:2];
  assign sel_stdout = (word == W_STDOUT);
  assign sel_exit   = (word == W_EXIT);
  assign sel_status = (word == W_STATUS);
  assign sel_cyc_lo = (word == W_CYC_LO);
  assign sel_cyc_hi = (word == W_CYC_HI);

  // Full check uses the registered count: a pop in the same cycle does not
  // free the slot until the next cycle, which keeps gnt off the pop path.
  assign data_gnt_o = data_req_i && !(data_we_i && sel_stdout && !fifo_in_rdy);
  assign bus_wr     = data_gnt_o && data_we_i;
  assign bus_rd     = data_gnt_o && !data_we_i;
  assign fifo_push  = bus_wr && sel_stdout && data_be_i[0];

  status_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_stdout_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_vld  (fifo_push),
    .in_dat  (data_wdata_i[7:0]),
    .in_rdy  (fifo_in_rdy),
    .out_vld (stdout_valid_o),
    .out_dat (stdout_data_o),
    .out_rdy (stdout_ready_i)
  );

  always_comb begin
    rd_val = '0;
    if (sel_cyc_lo)      rd_val = cycle_q[31:0];
    else if (sel_cyc_hi) rd_val = hi_shadow_q;
  end

  // Reading LO snapshots HI so a LO-then-HI pair is coherent across a carry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q     <= CYCLE_INIT;
      hi_shadow_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      cycle_q  <= cycle_q + 64'd1;
      rvalid_q <= data_gnt_o;
      rdata_q  <= bus_rd ? rd_val : '0;
      if (bus_rd && sel_cyc_lo) hi_shadow_q <= cycle_q[63:32];
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      kind_q     <= KIND_EXIT;
      exit_val_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      exit_val_q <= exit_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    exit_val_d = exit_val_q;
    case (state_q)
      ST_RUN: begin
        if (bus_wr && sel_exit) begin
          kind_d     = KIND_EXIT;
          exit_val_d = data_wdata_i;
          state_d    = ST_PENDING;
        end else if (bus_wr && sel_status) begin
          kind_d  = (data_wdata_i == PASS_MAGIC) ? KIND_PASS : KIND_FAIL;
          state_d = ST_PENDING;
        end
      end
      // Wait for the printer to drain everything, including any character
      // still being pushed, before raising the terminal flag.
      ST_PENDING: begin
        if (!stdout_valid_o && !fifo_push) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  assign tests_passed_o = (state_q == ST_DONE) && (kind_q == KIND_PASS);
  assign tests_failed_o = (state_q == ST_DONE) && (kind_q == KIND_FAIL);
  assign exit_valid_o   = (state_q == ST_DONE) && (kind_q == KIND_EXIT);
  assign exit_value_o   = exit_valid_o ? exit_val_q : '0;
endmodule

// File: tb/tb_tb_status_periph.sv
module tb_tb_status_periph;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] STDOUT = 32'h1000_0000;
  localparam logic [31:0] EXIT_A = 32'h2000_0000;
  localparam logic [31:0] STAT_A = 32'h2000_0004;
  localparam logic [31:0] LO_A   = 32'h2000_0008;
  localparam logic [31:0] HI_A   = 32'h2000_000C;
  localparam logic [31:0] MAGIC  = 32'd123456789;
  localparam logic [63:0] INIT   = 64'h0000_0000_FFFF_F000;

  logic        clk = 1'b0;
  logic        rst, req, we, ready;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        data_gnt_o, data_rvalid_o, stdout_valid_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] data_rdata_o, exit_value_o;
  logic [7:0]  stdout_data_o;

  tb_status_periph #(
    .FIFO_DEPTH(DEPTH), .STDOUT_ADDR(STDOUT), .CTRL_BASE(EXIT_A),
    .PASS_MAGIC(MAGIC), .CYCLE_INIT(INIT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_gnt_o(data_gnt_o), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .stdout_valid_o(stdout_valid_o), .stdout_data_o(stdout_data_o),
    .stdout_ready_i(ready),
    .tests_passed_o(tests_passed_o), .tests_failed_o(tests_failed_o),
    .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: character queue, expected response, terminal request
  // (0 none, 1 exit, 2 pass, 3 fail), and cycles elapsed since reset.
  bit [7:0]        mq[$];
  bit              m_rvalid, m_pend, m_done, last_gnt;
  bit [31:0]       m_rdata, m_shadow, m_code;
  int              m_term;
  longint unsigned m_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  // One clock cycle with the currently driven inputs: check gnt before the
  // edge, advance the model, check every registered output after the edge.
  task automatic step();
    bit          g, wr_std, push;
    logic [63:0] cyc;
    #1;
    last_gnt = data_gnt_o;
    if (rst) begin
      mq.delete();
      m_rvalid = 0; m_rdata = 0; m_shadow = 0; m_code = 0;
      m_term = 0; m_pend = 0; m_done = 0; m_n = 0;
    end else begin
      wr_std = we && is_word(addr, STDOUT);
      g      = req && !(wr_std && mq.size() == DEPTH);
      chk("gnt", data_gnt_o, g);
      push     = g && wr_std && be[0];
      cyc      = INIT + m_n;
      m_rvalid = g;
      m_rdata  = 0;
      if (g && !we) begin
        if (is_word(addr, LO_A)) begin
          m_rdata  = cyc[31:0];
          m_shadow = cyc[63:32];
        end else if (is_word(addr, HI_A)) begin
          m_rdata = m_shadow;
        end
      end
      if (m_pend) begin
        if (mq.size() == 0 && !push) begin m_pend = 0; m_done = 1; end
      end else if (!m_done && g && we) begin
        if (is_word(addr, EXIT_A)) begin m_term = 1; m_code = wdata; m_pend = 1; end
        else if (is_word(addr, STAT_A)) begin m_term = (wdata == MAGIC) ? 2 : 3; m_pend = 1; end
      end
      if (mq.size() != 0 && ready) void'(mq.pop_front());
      if (push) mq.push_back(wdata[7:0]);
      m_n++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rvalid", data_rvalid_o, m_rvalid);
    chk("rdata", data_rdata_o, m_rdata);
    chk("stdout_valid", stdout_valid_o, mq.size() != 0);
    chk("stdout_data", stdout_data_o, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("tests_passed", tests_passed_o, m_done && m_term == 2);
    chk("tests_failed", tests_failed_o, m_done && m_term == 3);
    chk("exit_valid", exit_valid_o, m_done && m_term == 1);
    chk("exit_value", exit_value_o, (m_done && m_term == 1) ? m_code : 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold the request until granted (bounded), then release it.
  task automatic access(input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1; we = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_gnt) break;
    end
    chk("gnt_within_bound", last_gnt, 1'b1);
    req = 0; we = 0; be = 0;
  endtask

  initial begin
    int unsigned op;
    int          guard;
    rst = 1; req = 0; we = 0; addr = 0; be = 0; wdata = 0; ready = 0;
    step(); step();
    rst = 0;

    // 'H','i' streamed straight through with the printer ready.
    ready = 1;
    access(1, STDOUT, 4'h1, 32'h48);
    chk("first_char", stdout_data_o, 8'h48);
    access(1, STDOUT, 4'h1, 32'h69);
    chk("second_char", stdout_data_o, 8'h69);
    idle(3);

    // Fill the FIFO, hold the 17th write, one pop unblocks it a cycle later.
    ready = 0;
    for (int i = 0; i < DEPTH; i++) access(1, STDOUT, 4'h1, 32'(i));
    req = 1; we = 1; addr = STDOUT; be = 4'h1; wdata = 32'h41;
    repeat (3) step();
    chk("full_held_gnt", last_gnt, 1'b0);
    ready = 1;
    step();
    chk("pop_cycle_gnt", last_gnt, 1'b0);
    chk("head_after_pop", stdout_data_o, 8'h01);
    ready = 0;
    step();
    chk("gnt_after_pop", last_gnt, 1'b1);
    req = 0; we = 0;
    ready = 1;
    idle(20);

    // Random traffic: stdout writes (random byte enables), counter reads,
    // unmapped and wrong-direction accesses, random printer readiness.
    for (int c = 0; c < 400; c++) begin
      if (!req || last_gnt) begin
        op = $urandom_range(0, 7);
        req = (op > 1); we = 0; be = 4'($urandom_range(0, 15)); wdata = $urandom;
        case (op)
          2, 3: begin we = 1; addr = STDOUT; end
          4: addr = LO_A;
          5: addr = HI_A;
          6: begin we = $urandom_range(0, 1); addr = 32'h3000_0000 + 32'($urandom_range(0, 255) * 4); end
          7: begin
            we = $urandom_range(0, 1);
            addr = we ? (($urandom_range(0, 1) != 0) ? LO_A : HI_A)
                      : (($urandom_range(0, 1) != 0) ? EXIT_A : STAT_A);
          end
          default: addr = 0;
        endcase
      end
      ready = $urandom_range(0, 1);
      step();
    end
    req = 0; we = 0;
    ready = 1;
    idle(20);

    // EXIT held back by five unprinted characters.
    ready = 0;
    for (int i = 0; i < 5; i++) access(1, STDOUT, 4'h1, 32'h61 + 32'(i));
    access(1, EXIT_A, 4'hF, 32'd3);
    idle(4);
    chk("exit_held", exit_valid_o, 1'b0);
    ready = 1;
    idle(8);
    chk("exit_after_drain", exit_valid_o, 1'b1);
    chk("exit_code", exit_value_o, 32'd3);
    access(1, STAT_A, 4'hF, MAGIC);
    idle(3);
    chk("exit_sticky", exit_valid_o, 1'b1);
    chk("late_pass_ignored", tests_passed_o, 1'b0);

    // LO read just before the 32-bit carry, HI read after it.
    guard = 0;
    while (m_n < 64'hFFE && guard < 8000) begin step(); guard++; end
    access(0, LO_A, 4'hF, 0);
    chk("lo_before_carry", data_rdata_o, 32'hFFFF_FFFE);
    idle(4);
    access(0, HI_A, 4'hF, 0);
    chk("hi_snapshot", data_rdata_o, 32'h0);
    access(0, LO_A, 4'hF, 0);
    access(0, HI_A, 4'hF, 0);
    chk("hi_after_carry", data_rdata_o, 32'h1);

    // PASS with empty FIFO: flag two cycles after grant; later EXIT ignored.
    rst = 1; step(); rst = 0;
    access(1, STAT_A, 4'hF, MAGIC);
    chk("pass_not_yet", tests_passed_o, 1'b0);
    step();
    chk("pass_latency", tests_passed_o, 1'b1);
    access(1, EXIT_A, 4'hF, 32'd7);
    idle(3);
    chk("exit_ignored", exit_valid_o, 1'b0);
    chk("exit_value_zero", exit_value_o, 32'h0);
    chk("pass_sticky", tests_passed_o, 1'b1);

    // Reset arriving with a read being granted drops the response.
    rst = 1; req = 1; we = 0; addr = LO_A;
    step();
    chk("rvalid_dropped", data_rvalid_o, 1'b0);
    chk("pass_cleared", tests_passed_o, 1'b0);
    rst = 0; req = 0;
    step();

    // TEST_STATUS with a non-magic value.
    access(1, STAT_A, 4'hF, 32'd1);
    idle(3);
    chk("fail_flag", tests_failed_o, 1'b1);
    chk("fail_not_pass", tests_passed_o, 1'b0);
    chk("fail_not_exit", exit_valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tb_status_periph.md
Name: tb_status_periph

Overview:
- Memory-mapped testbench peripheral on the core data bus, inside the RISC-V wrapper.
- Directly feeds the Verilator top level with tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o.
- Buffers stdout characters in a FIFO and drains them to a simulation-side printer over a valid/ready handshake.
- Holds every terminal status until the FIFO is empty, so all output is flushed before the bench calls $finish.

Parameters:
- FIFO_DEPTH, 16, stdout FIFO entries; power of two, >= 2.
- STDOUT_ADDR, 32'h1000_0000, word address of the stdout register.
- CTRL_BASE, 32'h2000_0000, base address of the 16-byte control window.
- PASS_MAGIC, 32'd123456789, value written to TEST_STATUS that signals pass.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- data_req_i  in  1  bus request.
- data_gnt_o  out  1  request accepted this cycle.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- stdout_valid_o  out  1  FIFO head character valid.
- stdout_data_o  out  8  FIFO head character.
- stdout_ready_i  in  1  printer accepts the character.
- tests_passed_o  out  1  sticky pass flag.
- tests_failed_o  out  1  sticky fail flag.
- exit_valid_o  out  1  sticky exit flag.
- exit_value_o  out  32  exit code.

Behaviour:
- Reset (rst_i sampled high at a clock edge) clears: FIFO pointers and count, pending status, all flags, cycle counter, and the HI shadow register. All outputs are 0 the cycle after reset, including mid-transaction; an in-flight rvalid is dropped.
- Decode, aligned word addresses:
  - STDOUT_ADDR: write only.
  - CTRL_BASE+0x0 EXIT: write only.
  - CTRL_BASE+0x4 TEST_STATUS: write only.
  - CTRL_BASE+0x8 CYCLE_LO: read only.
  - CTRL_BASE+0xC CYCLE_HI: read only.
  - Any other address, or the wrong direction on these registers: the access is granted, writes are ignored, reads return 0.
- Grant: data_gnt_o = data_req_i, except for a write to STDOUT while the FIFO is full. In that case gnt stays 0 and the master holds the request. A pop in the same cycle does not unblock it; the grant comes on the next cycle.
- Response: data_rvalid_o is asserted exactly 1 cycle after every grant, for reads and writes. data_rdata_o is valid with rvalid and is 0 whenever rvalid is 0.
- STDOUT write: pushes wdata[7:0] when be[0]=1. If be[0]=0, the write is granted and nothing is pushed.
- FIFO:
  - count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - stdout_valid_o = (count != 0); stdout_data_o = head entry.
  - Pop when valid && ready.
  - Push and pop in the same cycle leave count unchanged.
- Cycle counter: 64-bit, increments every cycle out of reset, wraps to 0.
  - Read CYCLE_LO: returns the low word and snapshots the high word into a shadow register in the same cycle.
  - Read CYCLE_HI: returns the shadow.
- Terminal status FSM, states RUN -> PENDING -> DONE:
  - RUN: a granted write to EXIT latches exit_value = wdata, kind=EXIT. A granted write to TEST_STATUS latches kind=PASS if wdata == PASS_MAGIC, otherwise kind=FAIL. Either write moves to PENDING.
  - PENDING: further EXIT/TEST_STATUS writes are granted and ignored (first write wins). STDOUT writes are still accepted. Move to DONE on the first cycle with count == 0 and no push.
  - DONE: assert the flag selected by kind, sticky until reset. Exactly one of tests_passed_o / tests_failed_o / exit_valid_o is ever 1. exit_value_o drives the latched value only with exit_valid_o, otherwise 0.
  - Minimum latency: with an empty FIFO, the write is granted in cycle N, the state is PENDING in N+1, and the flag is high in N+2.
- Single outstanding request per cycle; no simultaneous bus writes are possible.

Test Plan:
- Write 'H','i' to STDOUT with stdout_ready_i=1 -> stdout_valid_o/data_o show 0x48 then 0x69 on consecutive cycles; rvalid is 1 cycle after each gnt.
- FIFO_DEPTH=16, stdout_ready_i=0, 17 writes -> the 17th is held with gnt=0. Raise ready for one cycle -> 0x00 (first char) pops, and the 17th is granted on the following cycle.
- Write 5 chars, ready=0, then EXIT=3 -> exit_valid_o stays 0. Raise ready -> exit_valid_o=1 and exit_value_o=3 two cycles after the last pop, and the flag is sticky.
- TEST_STATUS=123456789 with FIFO empty -> tests_passed_o=1 two cycles after gnt. A later EXIT=7 is granted, rvalid returns, and no flag or value changes.
- TEST_STATUS=1 -> tests_failed_o=1; tests_passed_o and exit_valid_o stay 0.
- Preset the counter near 0x0000_0000_FFFF_FFFF, read CYCLE_LO then CYCLE_HI across the carry -> HI equals the snapshot taken at the LO read. Assert rst_i during a pending read -> rvalid and all flags are 0 the next cycle.
